tia_audio_i2s: RTL and testbench
================================

Name: tia_audio_i2s

Overview:
- Sink for the TIA tone generator's two 1-bit channel outputs (AUD0/AUD1).
- Applies the 4-bit volume registers and forms signed 16-bit PCM.
- Serializes left/right as standard I2S (Philips) to the board audio codec.
- Sits between the TIA audio generator and the codec pins, in the system clock domain.

Parameters:
- BCLK_DIV, 4: CLK cycles per BCLK half-period; legal values are 2 and above.
- SAMPLE_BITS, 16: bits per channel slot; the frame is 2*SAMPLE_BITS BCLKs. Only 16 is required to work.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-high reset
- EN  input  1  1 = play, 0 = transmit silence (all-zero samples); clocks keep running
- AUD0  input  1  channel 0 tone bit; asynchronous to CLK (CLK_30 domain)
- AUD1  input  1  channel 1 tone bit; asynchronous to CLK
- AUDV0  input  4  channel 0 volume, quasi-static
- AUDV1  input  4  channel 1 volume, quasi-static
- BCLK  output  1  I2S bit clock
- LRCLK  output  1  I2S word select; 0 = left
- SDATA  output  1  I2S serial data, MSB first
- SAMPLE_STB  output  1  one-CLK pulse when a new sample pair is latched

Behaviour:
- Reset (asynchronous):
  - BCLK=0, LRCLK=0, SDATA=0, SAMPLE_STB=0.
  - Divider=0, bit counter n=31, shift register=0, both synchronizer stages=0.
- Synchronizer: AUD0 and AUD1 each pass through two CLK flops before use.
- Divider:
  - Counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps to 0 and BCLK toggles.
  - BCLK period = 2*BCLK_DIV CLK cycles.
- Falling-edge events (1->0): all events below occur in the CLK cycle in which BCLK registers 0.
  - n advances mod 32 (31 wraps to 0).
  - SDATA and LRCLK update. Nothing updates on rising edges.
- LRCLK for new n: 0 when n=31 or n<=14; 1 when n=15..30. LRCLK therefore leads the data MSB by one BCLK.
- Slot n=0 (frame start):
  - Compute samples from the synchronized AUDx and current AUDVx.
  - Load shift register = {L[15:0], R[15:0]}.
  - SDATA = L[15] in the same cycle.
  - SAMPLE_STB = 1 for exactly that CLK cycle.
- Slots n=1..31: shift left one and SDATA = new MSB. Slots 16..31 carry R MSB..LSB.
- Sample arithmetic (stereo):
  - L = AUD0 ? +(AUDV0<<11) : -(AUDV0<<11); R likewise from AUD1/AUDV1.
  - Two's complement, range ±30720, no saturation needed.
  - AUDVx=0 gives 0 regardless of AUDx.
- EN=0 at frame start: L=R=0. EN is sampled only at n=0; a change mid-frame takes effect at the next frame.
- AUD/AUDV changes mid-frame do not affect the frame in flight.
- Reset mid-frame: outputs return to reset values immediately. The first falling edge after release is n=0 with a full load and SAMPLE_STB.
- Frame rate = f_CLK / (64*BCLK_DIV).

Optional Feature:
- Macro: TIA_AUDIO_MONO_MIX_EN.
- Defined:
  - M = (AUD0 ? +AUDV0 : -AUDV0) + (AUD1 ? +AUDV1 : -AUDV1), a 6-bit signed value.
  - L = R = M<<10; range ±30720.
  - EN=0 still gives 0.
- Not defined: independent stereo channels as in Behaviour.

Test Plan:
- Reset with BCLK_DIV=4, release: BCLK first toggles 1 after 4 CLKs. The first falling edge lands 8 CLKs later with n=0, SAMPLE_STB high for 1 CLK, LRCLK=0. Successive SAMPLE_STB pulses are exactly 256 CLKs apart.
- AUD0=1, AUDV0=15, AUD1=0, AUDV1=15, EN=1 held: each captured frame decodes to L=0x7800, R=0x8800. LRCLK falls one BCLK before the L MSB and rises one BCLK before the R MSB.
- AUDV0=0, AUDV1=5, AUD1=1: L=0x0000, R=0x2800. Then EN=0 set mid-frame: the current frame still carries R=0x2800 and the next frame is L=R=0.
- AUD0 toggled at an unrelated 30 kHz rate: no X on SDATA. L alternates only between +AUDV0<<11 and -AUDV0<<11, and the value changes only at frame boundaries.
- RESET asserted at n=20, held 3 CLKs: outputs go 0 asynchronously. After release, the first frame starts at n=0 with a fresh load.
- With TIA_AUDIO_MONO_MIX_EN defined: AUD0=1, AUDV0=15, AUD1=0, AUDV1=5 gives L=R=0x2800. AUD0=AUD1=1 with both volumes 15 gives L=R=0x7800.

Source files
------------

// File: rtl/tia_audio_i2s.sv
`default_nettype none
// ============================================================================
// Module   : tia_audio_i2s
// Purpose  : TIA AUD0/AUD1 tone bits + AUDV volumes -> signed PCM -> I2S out.
//            Define TIA_AUDIO_MONO_MIX_EN to mix both channels into L = R.
// Revision : 1.0  initial release
// ============================================================================
module tia_audio_i2s #(
  parameter int BCLK_DIV    = 4,
  parameter int SAMPLE_BITS = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       AUD0,
  input  logic       AUD1,
  input  logic [3:0] AUDV0,
  input  logic [3:0] AUDV1,
  output logic       BCLK,
  output logic       LRCLK,
  output logic       SDATA,
  output logic       SAMPLE_STB
);

  localparam int c_FRAME = 2 * SAMPLE_BITS;
  localparam int c_NW    = $clog2(c_FRAME);
  localparam int c_DW    = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic                   r_aud0_q1, r_aud0_q2, r_aud1_q1, r_aud1_q2;
  logic [c_DW-1:0]        r_div;
  logic [c_NW-1:0]        r_n;
  logic [c_FRAME-1:0]     r_shift;
  logic                   r_bclk, r_lrclk, r_sdata, r_stb;

  logic [SAMPLE_BITS-1:0] w_mag0, w_mag1, w_term0, w_term1, w_l, w_r;
  logic [c_FRAME-1:0]     w_load;
  logic [c_NW-1:0]        w_n_next;
  logic                   w_ws_next;

`ifdef TIA_AUDIO_MONO_MIX_EN
  // Mix at 2^10 scale so the sum of two full-scale channels stays in range
  assign w_mag0  = {{(SAMPLE_BITS-4){1'b0}}, AUDV0} << (SAMPLE_BITS - 6);
  assign w_mag1  = {{(SAMPLE_BITS-4){1'b0}}, AUDV1} << (SAMPLE_BITS - 6);
  assign w_term0 = r_aud0_q2 ? w_mag0 : -w_mag0;
  assign w_term1 = r_aud1_q2 ? w_mag1 : -w_mag1;
  assign w_l     = w_term0 + w_term1;
  assign w_r     = w_l;
`else
  assign w_mag0  = {{(SAMPLE_BITS-4){1'b0}}, AUDV0} << (SAMPLE_BITS - 5);
  assign w_mag1  = {{(SAMPLE_BITS-4){1'b0}}, AUDV1} << (SAMPLE_BITS - 5);
  assign w_term0 = r_aud0_q2 ? w_mag0 : -w_mag0;
  assign w_term1 = r_aud1_q2 ? w_mag1 : -w_mag1;
  assign w_l     = w_term0;
  assign w_r     = w_term1;
`endif

  assign w_load    = EN ? {w_l, w_r} : '0;
  assign w_n_next  = (r_n == c_NW'(c_FRAME - 1)) ? '0 : r_n + 1'b1;
  // Word select flips one BCLK ahead of each channel's MSB
  assign w_ws_next = (w_n_next >= c_NW'(SAMPLE_BITS - 1)) &&
                     (w_n_next != c_NW'(c_FRAME - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_aud0_q1 <= 1'b0;
      r_aud0_q2 <= 1'b0;
      r_aud1_q1 <= 1'b0;
      r_aud1_q2 <= 1'b0;
      r_div     <= '0;
      r_n       <= c_NW'(c_FRAME - 1);
      r_shift   <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
      r_stb     <= 1'b0;
    end else begin
      r_aud0_q1 <= AUD0;
      r_aud0_q2 <= r_aud0_q1;
      r_aud1_q1 <= AUD1;
      r_aud1_q2 <= r_aud1_q1;
      r_stb     <= 1'b0;
      if (r_div == c_DW'(BCLK_DIV - 1)) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
        if (r_bclk) begin
          r_n     <= w_n_next;
          r_lrclk <= w_ws_next;
          if (w_n_next == '0) begin
            r_shift <= w_load;
            r_sdata <= w_load[c_FRAME-1];
            r_stb   <= 1'b1;
          end else begin
            r_shift <= {r_shift[c_FRAME-2:0], 1'b0};
            r_sdata <= r_shift[c_FRAME-2];
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign BCLK       = r_bclk;
  assign LRCLK      = r_lrclk;
  assign SDATA      = r_sdata;
  assign SAMPLE_STB = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_tia_audio_i2s.sv
`default_nettype none
// ============================================================================
// Module   : tb_tia_audio_i2s
// Purpose  : Scoreboard bench: expected L/R per frame queued, I2S monitor checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_tia_audio_i2s;

  localparam int c_DIV    = 4;
  localparam int c_FRAMES = 24;

  logic       CLK = 1'b0;
  logic       RESET, EN, AUD0, AUD1;
  logic [3:0] AUDV0, AUDV1;
  logic       BCLK, LRCLK, SDATA, SAMPLE_STB;

  tia_audio_i2s #(.BCLK_DIV(c_DIV), .SAMPLE_BITS(16)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .AUD0(AUD0), .AUD1(AUD1),
    .AUDV0(AUDV0), .AUDV1(AUDV1), .BCLK(BCLK), .LRCLK(LRCLK),
    .SDATA(SDATA), .SAMPLE_STB(SAMPLE_STB)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;
  int frames_checked = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Reference: volume scaled to +/- full scale by plain integer arithmetic
  function automatic logic [31:0] model(input bit en, input bit a0, input bit a1,
                                        input int v0, input int v1);
    int l, r;
    l = 0;
    r = 0;
    if (en) begin
`ifdef TIA_AUDIO_MONO_MIX_EN
      l = ((a0 ? v0 : -v0) + (a1 ? v1 : -v1)) * 1024;
      r = l;
`else
      l = (a0 ? v0 : -v0) * 2048;
      r = (a1 ? v1 : -v1) * 2048;
`endif
    end
    return {l[15:0], r[15:0]};
  endfunction

  task automatic push_exp();
    exp_q.push_back(model(EN, AUD0, AUD1, int'(AUDV0), int'(AUDV1)));
  endtask

  // Monitor: collect 32 bits per frame on BCLK rising edges
  initial begin
    logic [31:0] bits, ws, ws_exp, e;
    int idx, cyc, last;
    bit in_frame, have_last, prev_b;
    for (int k = 0; k < 32; k++) ws_exp[31-k] = (((k + 1) % 32) >= 16);
    idx = 0; cyc = 0; last = 0; in_frame = 0; have_last = 0; prev_b = 0;
    bits = '0; ws = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RESET) begin
        in_frame  = 0;
        have_last = 0;
      end else if (SAMPLE_STB) begin
        if (have_last) chk("stb_spacing", 32'(cyc - last), 32'(64 * c_DIV));
        have_last = 1;
        last      = cyc;
        in_frame  = 1;
        idx       = 0;
      end else if (in_frame && BCLK && !prev_b) begin
        bits[31-idx] = SDATA;
        ws[31-idx]   = LRCLK;
        idx++;
        if (idx == 32) begin
          in_frame = 0;
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("left_sample", {16'h0, bits[31:16]}, {16'h0, e[31:16]});
            chk("right_sample", {16'h0, bits[15:0]}, {16'h0, e[15:0]});
            chk("lrclk_pattern", ws, ws_exp);
          end
          frames_checked++;
        end
      end
      prev_b = BCLK;
    end
  end

  task automatic wait_stb(output int cnt);
    cnt = 0;
    do begin
      @(negedge CLK);
      cnt++;
    end while (!SAMPLE_STB && cnt < 1000);
  endtask

  initial begin
    int cnt;
    RESET = 1'b1;
    EN = 1'b1; AUD0 = 1'b1; AUDV0 = 4'd15; AUD1 = 1'b0; AUDV1 = 4'd15;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {28'h0, BCLK, LRCLK, SDATA, SAMPLE_STB}, 32'h0);
    push_exp();
    RESET = 1'b0;

    cnt = 0;
    do begin @(negedge CLK); cnt++; end while (!BCLK && cnt < 100);
    chk("first_bclk_rise", 32'(cnt), 32'(c_DIV));
    do begin @(negedge CLK); cnt++; end while (!SAMPLE_STB && cnt < 100);
    chk("first_stb_latency", 32'(cnt), 32'(2 * c_DIV));
    chk("lrclk_at_frame_start", {31'h0, LRCLK}, 32'h0);
    @(negedge CLK);
    chk("stb_one_cycle", {31'h0, SAMPLE_STB}, 32'h0);

    for (int i = 0; i < c_FRAMES; i++) begin
      repeat (100) @(negedge CLK);
      case (i)
        0: begin EN = 1; AUD0 = 1; AUDV0 = 0; AUD1 = 1; AUDV1 = 5; end
        1: begin EN = 0; end
        2: begin EN = 1; AUD0 = 1; AUDV0 = 15; AUD1 = 0; AUDV1 = 5; end
        3: begin EN = 1; AUD0 = 1; AUDV0 = 15; AUD1 = 1; AUDV1 = 15; end
        default: begin
          EN    = ($urandom_range(0, 7) != 0);
          AUD0  = 1'($urandom_range(0, 1));
          AUD1  = 1'($urandom_range(0, 1));
          AUDV0 = 4'($urandom_range(0, 15));
          AUDV1 = 4'($urandom_range(0, 15));
        end
      endcase
      push_exp();
      wait_stb(cnt);
      if (cnt >= 1000) chk("stb_timeout", 32'd1, 32'd0);
    end

    // Abort the frame in flight around slot 20; inputs stay put so the
    // pending expectation applies to the first frame after release.
    repeat (20 * 2 * c_DIV + 2) @(negedge CLK);
    #1 RESET = 1'b1;
    #1 chk("async_reset_outputs", {28'h0, BCLK, LRCLK, SDATA, SAMPLE_STB}, 32'h0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    wait_stb(cnt);
    chk("post_reset_stb_latency", 32'(cnt), 32'(2 * c_DIV));

    cnt = 0;
    while (frames_checked < c_FRAMES + 1 && cnt < 2000) begin
      @(negedge CLK);
      cnt++;
    end
    chk("frames_completed", 32'(frames_checked), 32'(c_FRAMES + 1));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
